// File: rtl/btn_pkg.sv
// Shared types and helpers for the button gesture decoder: FSM states,
// default tick counts and the strobe-to-edge decode.
package btn_pkg;

    typedef enum logic [2:0] {
        IDLE,
        PRESSED,
        HELD,
        WAIT2,
        PRESSED2
    } btn_state_t;

    localparam int DEF_LONG_TICKS   = 500;
    localparam int DEF_DCLICK_TICKS = 250;
    localparam int DEF_REPEAT_TICKS = 100;
    localparam int DEF_CNT_W        = 16;

    typedef struct packed {
        logic press;
        logic rel;
    } btn_edges_t;

    // The filter strobe arrives together with the new level, so the level tells the edge direction.
    function automatic btn_edges_t decode_edges(input logic ceo, input logic level);
        btn_edges_t e;
        e.press = ceo & level;
        e.rel   = ceo & ~level;
        return e;
    endfunction

endpackage

// File: rtl/btn_tick_counter.sv
// CE-gated tick counter shared by the long-press, double-click and repeat
// timeouts; clears on request, saturates instead of wrapping.
module btn_tick_counter
    import btn_pkg::*;
#(
    parameter int CNT_W = DEF_CNT_W
) (
    input  logic             CLK,
    input  logic             RST,
    input  logic             ce,
    input  logic             clear,
    input  logic [CNT_W-1:0] last,
    output logic             terminal
);

    logic [CNT_W-1:0] count;

    always_ff @(posedge CLK) begin
        if (RST) begin
            count <= '0;
        end else if (clear) begin
            count <= '0;
        end else if (ce && (count != '1)) begin
            count <= count + CNT_W'(1);
        end
    end

    assign terminal = ce && (count == last);

endmodule

// File: rtl/btn_event_decoder.sv
// Turns the debounced button level and change strobe into single-cycle
// click, double-click, long-press and auto-repeat pulses.
module btn_event_decoder
    import btn_pkg::*;
#(
    parameter int LONG_TICKS   = DEF_LONG_TICKS,
    parameter int DCLICK_TICKS = DEF_DCLICK_TICKS,
    parameter int REPEAT_TICKS = DEF_REPEAT_TICKS,
    parameter int CNT_W        = DEF_CNT_W
) (
    input  logic CLK,
    input  logic RST,
    input  logic CE,
    input  logic BTN_IN,
    input  logic BTN_CEO,
    output logic EVT_CLICK,
    output logic EVT_DCLICK,
    output logic EVT_LONG,
    output logic EVT_REPEAT,
    output logic BUSY
);

    localparam logic [CNT_W-1:0] LONG_LAST   = CNT_W'(LONG_TICKS - 1);
    localparam logic [CNT_W-1:0] DCLICK_LAST = CNT_W'(DCLICK_TICKS - 1);
    localparam logic [CNT_W-1:0] REPEAT_LAST = CNT_W'(REPEAT_TICKS - 1);

    btn_state_t       state;
    btn_state_t       state_next;
    btn_edges_t       edges;
    logic             terminal;
    logic             cnt_clear;
    logic [CNT_W-1:0] cnt_last;
    logic             click_d;
    logic             dclick_d;
    logic             long_d;
    logic             repeat_d;

    assign edges = decode_edges(BTN_CEO, BTN_IN);

    always_comb begin
        cnt_last = '1;
        case (state)
            PRESSED: cnt_last = LONG_LAST;
            HELD:    cnt_last = REPEAT_LAST;
            WAIT2:   cnt_last = DCLICK_LAST;
            default: cnt_last = '1;
        endcase
    end

    // A repeat keeps the state but still has to restart the period.
    assign cnt_clear = (state_next != state) || repeat_d;

    btn_tick_counter #(
        .CNT_W (CNT_W)
    ) u_tick_counter (
        .CLK      (CLK),
        .RST      (RST),
        .ce       (CE),
        .clear    (cnt_clear),
        .last     (cnt_last),
        .terminal (terminal)
    );

    always_ff @(posedge CLK) begin
        if (RST) begin
            state <= IDLE;
        end else begin
            state <= state_next;
        end
    end

    // Edges take priority over a coincident timeout in every state.
    always_comb begin
        state_next = state;
        case (state)
            IDLE:     if (edges.press) state_next = PRESSED;
            PRESSED:  if (edges.rel) state_next = WAIT2;
                      else if (terminal) state_next = HELD;
            HELD:     if (edges.rel) state_next = IDLE;
            WAIT2:    if (edges.press) state_next = PRESSED2;
                      else if (terminal) state_next = IDLE;
            PRESSED2: if (edges.rel) state_next = IDLE;
            default:  state_next = IDLE;
        endcase
    end

    always_comb begin
        click_d  = 1'b0;
        dclick_d = 1'b0;
        long_d   = 1'b0;
        repeat_d = 1'b0;
        case (state)
            PRESSED:  long_d   = !edges.rel && terminal;
            HELD:     repeat_d = !edges.rel && terminal;
            WAIT2:    click_d  = !edges.press && terminal;
            PRESSED2: dclick_d = edges.rel;
            default:  ;
        endcase
    end

    always_ff @(posedge CLK) begin
        if (RST) begin
            EVT_CLICK  <= 1'b0;
            EVT_DCLICK <= 1'b0;
            EVT_LONG   <= 1'b0;
            EVT_REPEAT <= 1'b0;
        end else begin
            EVT_CLICK  <= click_d;
            EVT_DCLICK <= dclick_d;
            EVT_LONG   <= long_d;
            EVT_REPEAT <= repeat_d;
        end
    end

    assign BUSY = (state != IDLE);

endmodule

// File: doc/btn_event_decoder.md
Name: btn_event_decoder

Overview:
- Consumes the debounced level and change strobe produced by the button filter, i.e. its BTN_OUT and BTN_CEO outputs.
- Classifies user gestures into single-cycle event pulses: single click, double click, long press and auto-repeat while held.
- Sits between the button filter and the control logic, so that consumers never time button activity themselves.
- All timing counts in CE-qualified clock cycles; CE is typically a slow tick (e.g. 1 kHz) shared with the filter.

Parameters:
- LONG_TICKS, 500, CE ticks a press must be held before EVT_LONG fires (>=2).
- DCLICK_TICKS, 250, CE ticks after a release within which a second press counts as a double click (>=2).
- REPEAT_TICKS, 100, CE ticks between EVT_REPEAT pulses after EVT_LONG (>=2).
- CNT_W, 16, counter width; must satisfy 2^CNT_W > max(LONG_TICKS, DCLICK_TICKS, REPEAT_TICKS).

Ports:
- CLK  in  1  system clock.
- RST  in  1  synchronous reset, active-high.
- CE  in  1  tick enable; counters advance only when CE=1.
- BTN_IN  in  1  debounced button level (1 = pressed).
- BTN_CEO  in  1  one-cycle strobe; BTN_IN changed this cycle and already holds the new level.
- EVT_CLICK  out  1  one-cycle pulse on a single click.
- EVT_DCLICK  out  1  one-cycle pulse on a double click.
- EVT_LONG  out  1  one-cycle pulse when a long press is reached.
- EVT_REPEAT  out  1  one-cycle pulse, periodic while a long press is held.
- BUSY  out  1  high whenever state != IDLE.

Behaviour:
- Clocking and reset
  - Single clock domain. Reset is synchronous and active-high.
  - On RST: state=IDLE, counter=0, all outputs 0. Reset mid-gesture discards the gesture; no event fires on exit.
- Edge decoding
  - Press edge = BTN_CEO & BTN_IN.
  - Release edge = BTN_CEO & ~BTN_IN.
  - BTN_CEO is sampled every clock, independent of CE.
- Output timing
  - All outputs are registered.
  - An event pulse is high exactly one CLK cycle, in the cycle after the qualifying clock edge.
  - At most one EVT_* output is high in any cycle.
- Counter
  - CNT_W bits wide.
  - Cleared to 0 on every state transition.
  - Increments on CE otherwise.
  - "Terminal N" means counter==N-1 while CE=1.
- States
  - IDLE: press edge -> PRESSED.
  - PRESSED:
    - release edge -> WAIT2.
    - otherwise terminal LONG_TICKS -> EVT_LONG, go to HELD.
    - Release edge and terminal in the same cycle: release wins (no EVT_LONG).
  - HELD:
    - terminal REPEAT_TICKS -> EVT_REPEAT, counter cleared, stay in HELD.
    - release edge -> IDLE with no click event; release wins over a coincident repeat.
  - WAIT2:
    - press edge -> PRESSED2.
    - otherwise terminal DCLICK_TICKS -> EVT_CLICK, go to IDLE.
    - Press edge and timeout in the same cycle: press wins (double-click path, no EVT_CLICK).
  - PRESSED2:
    - release edge -> EVT_DCLICK, go to IDLE.
    - No long detection here; the counter saturates at 2^CNT_W-1 rather than wrapping.
- Inconsistent strobes (press edge while pressed, release edge while released) are ignored; state unchanged.
- CE=0: counters freeze, but edge-driven transitions still occur.
- BUSY is combinational from the state register, so it tracks the state with no extra latency.

Decomposition:
- Shared package btn_pkg holds:
  - the state enum (IDLE, PRESSED, HELD, WAIT2, PRESSED2);
  - default tick constants;
  - the edge-decode helper.
- One natural sub-module: btn_tick_counter. It is the CE-gated clear/terminal/saturating counter, reused for all three timeouts.
- FSM and output registers stay in the top-level block.

Test Plan:
All scenarios use LONG_TICKS=8, DCLICK_TICKS=4, REPEAT_TICKS=3, CE=1.
- Click: press strobe at t0, release strobe at t0+3 -> EVT_CLICK single pulse 5 cycles after release strobe; no other events; BUSY low afterwards.
- Double click: press, release after 2 cycles, press 2 cycles later, release after 2 cycles -> one EVT_DCLICK on cycle after second release; EVT_CLICK never asserted.
- Long + repeat: press held 20 cycles -> EVT_LONG about 9 cycles after press strobe, then EVT_REPEAT every 3 cycles; release -> no EVT_CLICK, IDLE next cycle.
- Coincidence: release strobe on exactly the LONG terminal cycle -> no EVT_LONG, state WAIT2. Second press on exactly the WAIT2 timeout cycle -> PRESSED2, no EVT_CLICK.
- CE gating: CE=1 one cycle in four, same click stimulus -> EVT_CLICK delayed proportionally (after 4 CE ticks); edges still tracked with CE=0.
- Reset mid-operation: assert RST for 1 cycle while in HELD -> all outputs 0 next cycle, BUSY=0; subsequent release strobe produces no event.
